// File: rtl/wmfifo_rr_drain.sv
// Round-robin drain of NPORT FIFO heads into one registered valid/stall output stage.
// Optional per-port grant counters: define WMFIFO_RR_DRAIN_PERF_EN.
module wmfifo_rr_drain #(
  parameter int NPORT = 8,
  parameter int WIDTH = 64,
  localparam int SRCW = (NPORT > 2) ? $clog2(NPORT) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NPORT-1:0]       in_empty,
  input  logic [NPORT*WIDTH-1:0] in_data,
  output logic [NPORT-1:0]       in_pop,
  input  logic [NPORT-1:0]       en_mask,
  output logic                   out_vld,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRCW-1:0]        out_src,
  input  logic                   out_stall,
`ifdef WMFIFO_RR_DRAIN_PERF_EN
  output logic [NPORT*32-1:0]    perf_gnt_cnt,
  input  logic                   perf_clr,
`endif
  output logic                   idle
);

  // Handshake: an entry leaves the output stage on any edge where out_vld=1 and
  // out_stall=0; a new head is popped (in_pop) in the same cycle it is loaded.

  logic             r_out_vld;
  logic [WIDTH-1:0] r_out_data;
  logic [SRCW-1:0]  r_out_src;
  logic [SRCW-1:0]  r_rr_ptr;
  logic             r_idle;

  logic [NPORT-1:0] w_req;
  logic [NPORT-1:0] w_gnt;
  logic [SRCW-1:0]  w_gnt_idx;
  logic             w_found;
  logic             w_load;
  logic             w_vld_next;

  assign w_req = ~in_empty & en_mask;

  // Reset gating keeps in_pop quiet while the output stage is being cleared.
  assign w_load = reset_n & (|w_req) & (~r_out_vld | ~out_stall);

  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!w_found && w_req[idx]) begin
        w_found    = 1'b1;
        w_gnt[idx] = 1'b1;
        w_gnt_idx  = SRCW'(idx);
      end
    end
  end

  assign in_pop     = w_load ? w_gnt : '0;
  assign w_vld_next = w_load | (r_out_vld & out_stall);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_src  <= '0;
      r_rr_ptr   <= '0;
      r_idle     <= 1'b1;
    end else begin
      r_out_vld <= w_vld_next;
      r_idle    <= ~w_vld_next & ~(|w_req);
      if (w_load) begin
        r_out_data <= in_data[int'(w_gnt_idx)*WIDTH +: WIDTH];
        r_out_src  <= w_gnt_idx;
        r_rr_ptr   <= (w_gnt_idx == SRCW'(NPORT-1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  assign out_vld  = r_out_vld;
  assign out_data = r_out_data;
  assign out_src  = r_out_src;
  assign idle     = r_idle;

`ifdef WMFIFO_RR_DRAIN_PERF_EN
  logic [31:0] r_perf [NPORT];

  for (genvar g = 0; g < NPORT; g++) begin : g_perf
    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_perf[g] <= '0;
      end else if (perf_clr) begin
        r_perf[g] <= '0;
      end else if (w_load && w_gnt[g] && (r_perf[g] != 32'hFFFF_FFFF)) begin
        r_perf[g] <= r_perf[g] + 32'd1;
      end
    end
    assign perf_gnt_cnt[g*32 +: 32] = r_perf[g];
  end
`endif

endmodule

// File: doc/wmfifo_rr_drain.md
Name: wmfifo_rr_drain

Overview:
- Downstream drain stage for a bank of watermark FIFOs that feed one memory-controller request port.
- Arbitrates round-robin among non-empty FIFO heads and pops the winner.
- Registers the winning entry, plus its source index, into a single output stage with valid/stall flow control.
- Sits between the per-lane request FIFOs (registered-output mode) and the MC request interface.

Parameters:
- NPORT, 8, number of FIFO inputs (2..16).
- WIDTH, 64, payload width per FIFO entry.
- SRCW, derived localparam = max(1, ceil(log2(NPORT))), width of the source index.

Ports:
- clk  in  1  single clock; all FIFOs and the output share it.
- reset_n  in  1  asynchronous, active-low reset.
- in_empty  in  NPORT  per-FIFO empty flag; head data is valid when low.
- in_data  in  NPORT*WIDTH  concatenated FIFO heads; port i occupies bits [i*WIDTH +: WIDTH].
- in_pop  out  NPORT  one-hot pop to the FIFOs; combinational, same cycle as the grant.
- en_mask  in  NPORT  per-port enable; 0 excludes the port from arbitration.
- out_vld  out  1  output register holds a valid request.
- out_data  out  WIDTH  registered payload.
- out_src  out  SRCW  registered index of the port that supplied out_data.
- out_stall  in  1  downstream stall; out_vld/out_data/out_src hold while stall is asserted and out_vld is high.
- idle  out  1  registered; high when out_vld=0 and every enabled in_empty is high.

Behaviour:
- Reset (reset_n low, asynchronous): out_vld=0, out_data=0, out_src=0, rr_ptr=0, idle=1. in_pop=0 while reset_n is low.
- Request vector: req[i] = ~in_empty[i] & en_mask[i].
- Load condition: load = |req & (~out_vld | ~out_stall).
  - Output register may refill in the same cycle it is consumed, giving a full-throughput stream of one entry per clock.
- Grant:
  - Round-robin search starting at rr_ptr, ascending with wrap from NPORT-1 to 0.
  - First i with req[i]=1 wins; gnt is one-hot.
- in_pop = load ? gnt : 0. Never asserted to an empty or masked port, and never asserted while the output register is stalled full.
- On load, at the clock edge:
  - out_data <= in_data[gnt_idx]
  - out_src <= gnt_idx
  - out_vld <= 1
  - rr_ptr <= (gnt_idx == NPORT-1) ? 0 : gnt_idx+1
- No load and no stall: out_vld <= 0. out_data and out_src keep their last values (don't-care).
- Stall with out_vld=1: all output registers hold; rr_ptr holds.
- Stall with out_vld=0: stall is ignored and a load proceeds.
- Latency: a FIFO going non-empty at edge N produces out_vld=1 after edge N+1, provided it wins arbitration.
- Fairness: with all NPORT ports continuously requesting, each port is granted exactly once per NPORT consecutive loads.
- Single requester: granted every cycle regardless of rr_ptr.
- en_mask change: takes effect the same cycle. An entry already in the output register is unaffected.
- Reset mid-stream: an in-flight output entry is discarded (out_vld=0 immediately). Upstream FIFOs are reset by their own reset.
- idle is registered from the next-state values.

Optional Feature:
- Macro: WMFIFO_RR_DRAIN_PERF_EN.
- Defined:
  - Adds output perf_gnt_cnt, NPORT*32 bits: per-port 32-bit saturating counts of loads.
  - Adds input perf_clr, 1 bit: synchronous clear of all counters; it takes priority over a same-cycle increment.
  - Counters reset to 0 on reset_n low.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset with all FIFOs empty, then release reset_n → out_vld=0, idle=1, in_pop=0 for 10 cycles.
- Ports 0, 3, 5 each preloaded with 4 entries, out_stall=0 → out_src sequence 0,3,5,0,3,5,… for 12 back-to-back cycles; every in_pop is one-hot; idle=1 two cycles after the last load.
- Port 2 only, 5 entries; out_stall held high for cycles 2-6 → out_data frozen on entry 1 and in_pop=0 throughout the stall; entries 1-5 emerge in order with no loss or duplication.
- All 8 ports always non-empty, 800 loads → each out_src value appears exactly 100 times; no port is granted twice within any 8-load window.
- Ports 1 and 6 non-empty, en_mask[6] cleared mid-run → port 6 is never popped after that cycle; port 1 is granted every cycle.
- reset_n pulsed low while out_vld=1 and out_stall=1 → out_vld drops asynchronously; after release the next grant starts the round-robin search from port 0.
